csr_access_seq: RTL and testbench

Multi-cycle sequencer that executes RISC-V Zicsr instructions (CSRRW/RS/RC and immediate forms) against the CSR unit. It sits between the execute stage and the CSR unit: it accepts a decoded CSR instruction and reads the addressed CSR. It then performs the read-modify-write, checks privilege and read-only rules, and returns the old CSR value for writeback to rd.

---
 rtl/csr_access_seq_if.sv | 36 +++
 rtl/csr_access_seq.sv | 116 +++++++++++
 tb/tb_csr_access_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/csr_access_seq_if.sv
`default_nettype none
// ============================================================================
// csr_access_seq_if : request/CSR-port/writeback bundle of the CSR sequencer
// Revision 1.0
// ============================================================================
interface csr_access_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [11:0]     csr_addr;
  logic [4:0]      rs1_field;
  logic [4:0]      rd_idx;
  logic [XLEN-1:0] rs1_data;
  logic [1:0]      cpm;
  logic [XLEN-1:0] csr_rdata;
  logic [11:0]     csr_addr_o;
  logic            csr_wr;
  logic [XLEN-1:0] csr_wdata;
  logic            busy;
  logic            done;
  logic            rd_we;
  logic [XLEN-1:0] rd_data;
  logic            illegal;

  modport slave (
    input  start, funct3, csr_addr, rs1_field, rd_idx, rs1_data, cpm, csr_rdata,
    output csr_addr_o, csr_wr, csr_wdata, busy, done, rd_we, rd_data, illegal
  );

  modport master (
    output start, funct3, csr_addr, rs1_field, rd_idx, rs1_data, cpm, csr_rdata,
    input  csr_addr_o, csr_wr, csr_wdata, busy, done, rd_we, rd_data, illegal
  );
endinterface
`default_nettype wire

// File: rtl/csr_access_seq.sv
`default_nettype none
// ============================================================================
// csr_access_seq : multi-cycle Zicsr read-modify-write sequencer
// Revision 1.0
// ============================================================================
module csr_access_seq #(
  parameter int XLEN = 32
) (
  input  wire logic         clk,
  input  wire logic         rst,
  csr_access_seq_if.slave   bus
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_READ  = 2'd1;
  localparam logic [1:0] c_WRITE = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic [11:0]     addr_q, addr_d;
  logic [4:0]      rs1f_q, rs1f_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] rs1d_q, rs1d_d;
  logic [1:0]      cpm_q, cpm_d;
  logic [XLEN-1:0] old_q, old_d;
  logic            illegal_q, illegal_d;

  logic [XLEN-1:0] w_src;
  logic            w_wi;
  logic            w_illegal;

  // Immediate forms use the rs1 field itself as a zero-extended uimm.
  assign w_src     = f3_q[2] ? {{(XLEN-5){1'b0}}, rs1f_q} : rs1d_q;
  assign w_wi      = (f3_q[1:0] == 2'b01) || (rs1f_q != 5'd0);
  assign w_illegal = (f3_q[1:0] == 2'b00) || (cpm_q < addr_q[9:8]) ||
                     ((addr_q[11:10] == 2'b11) && w_wi);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= c_IDLE;
      f3_q      <= '0;
      addr_q    <= '0;
      rs1f_q    <= '0;
      rd_q      <= '0;
      rs1d_q    <= '0;
      cpm_q     <= '0;
      old_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      f3_q      <= f3_d;
      addr_q    <= addr_d;
      rs1f_q    <= rs1f_d;
      rd_q      <= rd_d;
      rs1d_q    <= rs1d_d;
      cpm_q     <= cpm_d;
      old_q     <= old_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    rs1f_d    = rs1f_q;
    rd_d      = rd_q;
    rs1d_d    = rs1d_q;
    cpm_d     = cpm_q;
    old_d     = old_q;
    illegal_d = illegal_q;
    case (state_q)
      c_IDLE: begin
        if (bus.start) begin
          f3_d    = bus.funct3;
          addr_d  = bus.csr_addr;
          rs1f_d  = bus.rs1_field;
          rd_d    = bus.rd_idx;
          rs1d_d  = bus.rs1_data;
          cpm_d   = bus.cpm;
          state_d = c_READ;
        end
      end
      c_READ: begin
        old_d     = bus.csr_rdata;
        illegal_d = w_illegal;
        state_d   = (!w_illegal && w_wi) ? c_WRITE : c_DONE;
      end
      c_WRITE: state_d = c_DONE;
      c_DONE:  state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    bus.csr_addr_o = addr_q;
    bus.csr_wr     = (state_q == c_WRITE);
    bus.csr_wdata  = '0;
    if (state_q == c_WRITE) begin
      case (f3_q[1:0])
        2'b01:   bus.csr_wdata = w_src;
        2'b10:   bus.csr_wdata = old_q | w_src;
        2'b11:   bus.csr_wdata = old_q & ~w_src;
        default: bus.csr_wdata = '0;
      endcase
    end
    bus.busy    = (state_q != c_IDLE);
    bus.done    = (state_q == c_DONE);
    bus.rd_we   = (state_q == c_DONE) && !illegal_q && (rd_q != 5'd0);
    bus.rd_data = (state_q == c_DONE) ? old_q : '0;
    bus.illegal = (state_q == c_DONE) && illegal_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_csr_access_seq.sv
`default_nettype none
// ============================================================================
// tb_csr_access_seq : directed and randomized checks against a Zicsr model
// Revision 1.0
// ============================================================================
module tb_csr_access_seq;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [31:0] mem [0:4095];

  csr_access_seq_if #(.XLEN(32)) bus ();

  csr_access_seq #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR unit stand-in: combinational read, commit on the edge ending WRITE.
  assign bus.csr_rdata = mem[bus.csr_addr_o];
  always @(posedge clk) if (bus.csr_wr) mem[bus.csr_addr_o] <= bus.csr_wdata;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  task automatic scramble();
    bus.funct3    = 3'($urandom);
    bus.csr_addr  = 12'($urandom);
    bus.rs1_field = 5'($urandom);
    bus.rd_idx    = 5'($urandom);
    bus.rs1_data  = $urandom;
    bus.cpm       = 2'($urandom);
  endtask

  // Issue one instruction in the current cycle and check it against the
  // architectural Zicsr rules.
  task automatic do_op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1,
                       input logic [4:0] rd, input logic [31:0] d, input logic [1:0] pm,
                       input string nm);
    logic [31:0] old, src, nv, wr_data, got_rd;
    logic        legal, wi, wr, got_we, got_ill;
    int          wr_cnt, wr_cyc, done_cyc, bad_busy, bad_addr;
    old   = mem[a];
    src   = f3[2] ? {27'd0, r1} : d;
    wi    = (f3[1:0] == 2'b01) || (r1 != 0);
    legal = (f3 != 3'b000) && (f3 != 3'b100) && (pm >= a[9:8]) && !(a[11:10] == 2'b11 && wi);
    wr    = legal && wi;
    nv    = (f3[1:0] == 2'b01) ? src : (f3[1:0] == 2'b10) ? (old | src) : (old & ~src);
    if (!wr) nv = old;

    bus.start = 1'b1; bus.funct3 = f3; bus.csr_addr = a; bus.rs1_field = r1;
    bus.rd_idx = rd; bus.rs1_data = d; bus.cpm = pm;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    scramble();
    wr_cnt = 0; wr_cyc = 0; done_cyc = 0; bad_busy = 0; bad_addr = 0;
    wr_data = 0; got_rd = 0; got_we = 0; got_ill = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) bad_busy++;
      if (bus.csr_addr_o !== a) bad_addr++;
      if (bus.csr_wr === 1'b1) begin wr_cnt++; wr_cyc = k; wr_data = bus.csr_wdata; end
      if (bus.done === 1'b1) begin
        done_cyc = k; got_rd = bus.rd_data; got_we = bus.rd_we; got_ill = bus.illegal;
        break;
      end
    end
    chk({nm, " latency"}, 32'(done_cyc), wr ? 32'd3 : 32'd2);
    chk({nm, " rd_data"}, got_rd, old);
    chk({nm, " rd_we"}, {31'd0, got_we}, {31'd0, legal && rd != 0});
    chk({nm, " illegal"}, {31'd0, got_ill}, {31'd0, !legal});
    chk({nm, " wr_count"}, 32'(wr_cnt), wr ? 32'd1 : 32'd0);
    if (wr) begin
      chk({nm, " wr_cycle"}, 32'(wr_cyc), 32'd2);
      chk({nm, " wdata"}, wr_data, nv);
    end
    chk({nm, " busy_gaps"}, 32'(bad_busy), 32'd0);
    chk({nm, " addr_o"}, 32'(bad_addr), 32'd0);
    @(posedge clk);
    #1;
    chk({nm, " csr_value"}, mem[a], nv);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    scramble();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset csr_wr", {31'd0, bus.csr_wr}, 32'd0);
    chk("reset addr_o", {20'd0, bus.csr_addr_o}, 32'd0);
    chk("reset misc", {bus.csr_wdata | bus.rd_data}, 32'd0);
    chk("reset flags", {30'd0, bus.rd_we, bus.illegal}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    mem[12'h340] = 32'h12345678;
    do_op(3'b001, 12'h340, 5'd9, 5'd5, 32'hDEADBEEF, 2'd3, "csrrw");
    mem[12'h00F] = 32'h0000000F;
    do_op(3'b010, 12'h00F, 5'd7, 5'd6, 32'h000000F0, 2'd3, "csrrs");
    mem[12'h0FF] = 32'h000000FF;
    do_op(3'b111, 12'h0FF, 5'd3, 5'd7, 32'hFFFFFFFF, 2'd3, "csrrci");
    mem[12'hF14] = 32'h00000000;
    do_op(3'b010, 12'hF14, 5'd0, 5'd0, 32'h55555555, 2'd3, "ro_read");
    do_op(3'b001, 12'h300, 5'd1, 5'd4, 32'h0000AAAA, 2'd0, "ill_priv");
    do_op(3'b001, 12'hF11, 5'd1, 5'd4, 32'h0000AAAA, 2'd3, "ill_ro");
    do_op(3'b100, 12'h340, 5'd1, 5'd4, 32'h0000AAAA, 2'd3, "ill_f3");
  endtask

  task automatic test_reset_mid_write();
    mem[12'h341] = 32'h11111111;
    bus.start = 1'b1; bus.funct3 = 3'b001; bus.csr_addr = 12'h341; bus.rs1_field = 5'd2;
    bus.rd_idx = 5'd8; bus.rs1_data = 32'hCAFEF00D; bus.cpm = 2'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst in_write", {31'd0, bus.csr_wr}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst outputs", {29'd0, bus.csr_wr, bus.busy, bus.done}, 32'd0);
    @(negedge clk);
    chk("midrst write_lost", mem[12'h341], 32'h11111111);
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_op(3'b001, 12'h341, 5'd2, 5'd8, 32'hCAFEF00D, 2'd3, "after_rst");
  endtask

  task automatic test_start_held();
    logic [8:0] done_v, wr_v;
    done_v = '0; wr_v = '0;
    mem[12'h342] = 32'h0;
    bus.start = 1'b1; bus.funct3 = 3'b001; bus.csr_addr = 12'h342; bus.rs1_field = 5'd1;
    bus.rd_idx = 5'd3; bus.rs1_data = 32'h0000A5A5; bus.cpm = 2'd3;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      done_v[k] = bus.done;
      wr_v[k]   = bus.csr_wr;
    end
    bus.start = 1'b0;
    chk("held done_pattern", {23'd0, done_v}, 32'b0_1000_1000);
    chk("held wr_pattern", {23'd0, wr_v}, 32'b0_0100_0100);
    repeat (3) @(negedge clk);
    chk("held idle_after", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [1:0]  pms [3] = '{2'd0, 2'd1, 2'd3};
    logic [4:0]  r1;
    for (int i = 0; i < 40; i++) begin
      r1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      do_op(3'($urandom), 12'($urandom), r1, 5'($urandom), $urandom,
            pms[$urandom_range(0, 2)], $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    test_reset();
    test_directed();
    test_reset_mid_write();
    test_start_held();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
